sram_mem_responder: RTL and testbench

Responder for the cache's mem_* port: the memory side of the interface that hybrid_cache drives as initiator. It replaces the testbench memory model with a real controller. Each 32-bit word access is translated into two 16-bit accesses to an external asynchronous SRAM, with a programmable number of wait states. Sits between hybrid_cache and the board SRAM pins.

---
 rtl/mem_resp_pkg.sv | 35 +++
 rtl/mem_wait_counter.sv | 31 +++
 rtl/sram_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_sram_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the SRAM-backed memory responder.
// Holds the FSM state encoding, halfword selects and nominal access latencies.
package mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_LO     = 3'd1,
    RD_HI     = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5
  } mem_state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int DEFAULT_WAITSTATES = 2;

  function automatic int rd_latency(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int wr_latency(input int w);
    return 2 * w + 6;
  endfunction

  // Counter must hold WAITSTATES; a zero-wait build still needs one bit.
  function automatic int wait_cnt_bits(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

  localparam int RD_LAT = rd_latency(DEFAULT_WAITSTATES);
  localparam int WR_LAT = wr_latency(DEFAULT_WAITSTATES);

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: reloads WAITSTATES on every phase entry and
// flags zero when the current phase may advance.
module mem_wait_counter
  import mem_resp_pkg::*;
#(
  parameter int WAITSTATES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic zero
);

  localparam int CNTBITS = wait_cnt_bits(WAITSTATES);
  localparam logic [CNTBITS-1:0] LOAD_VAL = CNTBITS'(WAITSTATES);

  logic [CNTBITS-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/sram_mem_responder.sv
// Memory-port responder for hybrid_cache: splits each 32-bit access into two
// 16-bit asynchronous SRAM accesses with programmable wait states.
module sram_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDRBITS      = 32,
  parameter int DATABITS      = 32,
  parameter int SRAM_ADDRBITS = 18,
  parameter int WAITSTATES    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDRBITS-1:0]      mem_addr,
  input  logic [DATABITS-1:0]      mem_in,
  output logic [DATABITS-1:0]      mem_out,
  output logic                     mem_out_valid,
  input  logic                     mem_wrreq,
  input  logic                     mem_rdreq,
  output logic [SRAM_ADDRBITS-1:0] sram_addr,
  output logic [15:0]              sram_dq_out,
  input  logic [15:0]              sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n
);

  localparam int WA = SRAM_ADDRBITS - 1;

  mem_state_e state_reg, state_next;
  logic                     half_reg, half_next;
  logic [WA-1:0]            addr_reg, addr_next;
  logic [DATABITS-1:0]      data_reg, data_next;
  logic [DATABITS-1:0]      mem_out_reg, mem_out_next;
  logic                     valid_reg, valid_next;
  logic [SRAM_ADDRBITS-1:0] sram_addr_reg, sram_addr_next;
  logic [15:0]              dq_out_reg, dq_out_next;
  logic                     dq_oe_reg, dq_oe_next;
  logic                     ce_n_reg, ce_n_next;
  logic                     oe_n_reg, oe_n_next;
  logic                     we_n_reg, we_n_next;
  logic                     wait_load, wait_zero;

  // Bits above the SRAM window and the byte offset do not select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[ADDRBITS-1:SRAM_ADDRBITS+1], mem_addr[1:0]};

  mem_wait_counter #(
    .WAITSTATES(WAITSTATES)
  ) u_wait (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (wait_load),
    .zero   (wait_zero)
  );

  always_comb begin
    state_next   = state_reg;
    half_next    = half_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    mem_out_next = mem_out_reg;
    case (state_reg)
      IDLE: begin
        if (mem_wrreq) begin
          state_next = WR_SETUP;
          half_next  = HALF_LO;
          addr_next  = mem_addr[SRAM_ADDRBITS:2];
          data_next  = mem_in;
        end else if (mem_rdreq) begin
          state_next = RD_LO;
          half_next  = HALF_LO;
          addr_next  = mem_addr[SRAM_ADDRBITS:2];
        end
      end
      RD_LO: begin
        if (wait_zero) begin
          state_next      = RD_HI;
          half_next       = HALF_HI;
          data_next[15:0] = sram_dq_in;
        end
      end
      RD_HI: begin
        if (wait_zero) begin
          state_next   = IDLE;
          mem_out_next = {sram_dq_in, data_reg[15:0]};
        end
      end
      WR_SETUP:  state_next = WR_STROBE;
      WR_STROBE: if (wait_zero) state_next = WR_HOLD;
      WR_HOLD: begin
        if (half_reg == HALF_HI) begin
          state_next = IDLE;
        end else begin
          state_next = WR_SETUP;
          half_next  = HALF_HI;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pad controls are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    wait_load      = (state_next != state_reg);
    valid_next     = (state_next == IDLE);
    ce_n_next      = (state_next == IDLE);
    oe_n_next      = !((state_next == RD_LO) || (state_next == RD_HI));
    we_n_next      = (state_next != WR_STROBE);
    dq_oe_next     = (state_next == WR_SETUP) || (state_next == WR_STROBE) ||
                     (state_next == WR_HOLD);
    sram_addr_next = sram_addr_reg;
    dq_out_next    = dq_out_reg;
    if (state_next != IDLE) begin
      sram_addr_next = {addr_next, half_next};
    end
    if (dq_oe_next) begin
      dq_out_next = (half_next == HALF_HI) ? data_next[31:16] : data_next[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      half_reg      <= HALF_LO;
      addr_reg      <= '0;
      data_reg      <= '0;
      mem_out_reg   <= '0;
      valid_reg     <= 1'b1;
      sram_addr_reg <= '0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      half_reg      <= half_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      mem_out_reg   <= mem_out_next;
      valid_reg     <= valid_next;
      sram_addr_reg <= sram_addr_next;
      dq_out_reg    <= dq_out_next;
      dq_oe_reg     <= dq_oe_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
    end
  end

  assign mem_out       = mem_out_reg;
  assign mem_out_valid = valid_reg;
  assign sram_addr     = sram_addr_reg;
  assign sram_dq_out   = dq_out_reg;
  assign sram_dq_oe    = dq_oe_reg;
  assign sram_ce_n     = ce_n_reg;
  assign sram_oe_n     = oe_n_reg;
  assign sram_we_n     = we_n_reg;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: lane 0 uses 2 wait states, lane 1 uses none.
// Each lane has an SRAM pad model, a word-level reference memory and a per-cycle compare.
module tb_sram_mem_responder;

  localparam int NL = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_addr [NL];
  logic [31:0] mem_in [NL];
  logic [31:0] mem_out [NL];
  logic        mem_out_valid [NL];
  logic        mem_wrreq [NL];
  logic        mem_rdreq [NL];
  logic [17:0] sram_addr [NL];
  logic [15:0] sram_dq_out [NL];
  logic        sram_dq_oe [NL];
  logic        sram_ce_n [NL];
  logic        sram_oe_n [NL];
  logic        sram_we_n [NL];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  for (genvar gi = 0; gi < NL; gi++) begin : lane
    localparam int W   = (gi == 0) ? 2 : 0;
    localparam int RDL = 2 * W + 2;
    localparam int WRL = 2 * W + 6;

    logic [15:0] sram_mem [int];
    logic [31:0] mem_model [int];
    logic [15:0] dq_in = 16'h0;
    int          m_rem = 0;
    logic        m_wr = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_data = '0;
    logic [31:0] exp_out = '0;
    logic [17:0] rd_log [64];
    int          rd_n = 0;
    logic        prev_rd = 1'b0;
    logic [17:0] prev_addr = '0;
    int          we_len_log [64];
    logic [17:0] we_addr_log [64];
    int          we_cnt = 0;
    int          we_cur = 0;

    sram_mem_responder #(
      .ADDRBITS(32), .DATABITS(32), .SRAM_ADDRBITS(18), .WAITSTATES(W)
    ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_addr     (mem_addr[gi]),
      .mem_in       (mem_in[gi]),
      .mem_out      (mem_out[gi]),
      .mem_out_valid(mem_out_valid[gi]),
      .mem_wrreq    (mem_wrreq[gi]),
      .mem_rdreq    (mem_rdreq[gi]),
      .sram_addr    (sram_addr[gi]),
      .sram_dq_out  (sram_dq_out[gi]),
      .sram_dq_in   (dq_in),
      .sram_dq_oe   (sram_dq_oe[gi]),
      .sram_ce_n    (sram_ce_n[gi]),
      .sram_oe_n    (sram_oe_n[gi]),
      .sram_we_n    (sram_we_n[gi])
    );

    // Asynchronous SRAM read path settles well before the next capture edge.
    always @(negedge clk) begin
      if (!sram_ce_n[gi] && !sram_oe_n[gi])
        dq_in = sram_mem.exists(int'(sram_addr[gi])) ? sram_mem[int'(sram_addr[gi])] : 16'h0;
      else
        dq_in = 16'hdead;
    end

    always @(posedge clk) begin
      if (!sram_ce_n[gi] && !sram_we_n[gi] && sram_dq_oe[gi])
        sram_mem[int'(sram_addr[gi])] = sram_dq_out[gi];
      if (!sram_ce_n[gi] && !sram_oe_n[gi] && (!prev_rd || sram_addr[gi] != prev_addr)) begin
        rd_log[rd_n % 64] = sram_addr[gi];
        rd_n++;
      end
      prev_rd   = !sram_ce_n[gi] && !sram_oe_n[gi];
      prev_addr = sram_addr[gi];
      if (!sram_we_n[gi]) begin
        if (we_cur == 0) we_addr_log[we_cnt % 64] = sram_addr[gi];
        we_cur++;
      end else if (we_cur > 0) begin
        we_len_log[we_cnt % 64] = we_cur;
        we_cnt++;
        we_cur = 0;
      end
    end

    // Word-level reference: idle accepts, write wins, completes after the fixed latency.
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        m_rem   = 0;
        exp_out = '0;
      end else if (m_rem == 0) begin
        if (mem_wrreq[gi] || mem_rdreq[gi]) begin
          m_wr   = mem_wrreq[gi];
          m_rem  = m_wr ? WRL : RDL;
          m_idx  = int'((mem_addr[gi] % 32'h0008_0000) / 4);
          m_data = mem_in[gi];
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_wr) mem_model[m_idx] = m_data;
          else exp_out = mem_model.exists(m_idx) ? mem_model[m_idx] : 32'h0;
        end
      end
    end

    always @(negedge clk) begin
      if (reset_n) begin
        check($sformatf("L%0d_valid", gi), {31'b0, mem_out_valid[gi]}, {31'b0, m_rem == 0});
        if (m_rem == 0) check($sformatf("L%0d_mem_out", gi), mem_out[gi], exp_out);
        if (!sram_oe_n[gi] && sram_dq_oe[gi])
          check($sformatf("L%0d_oe_dq_exclusive", gi), 32'd1, 32'd0);
      end
    end
  end

  task automatic wait_idle(input int l);
    int n = 0;
    while (!mem_out_valid[l] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!mem_out_valid[l]) check($sformatf("L%0d_idle_timeout", l), 32'd0, 32'd1);
  endtask

  task automatic start_op(input int l, input bit wr, input bit rd,
                          input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wait_idle(l);
    mem_addr[l] = a; mem_in[l] = d; mem_wrreq[l] = wr; mem_rdreq[l] = rd;
    @(posedge clk); #1;
    mem_wrreq[l] = 1'b0; mem_rdreq[l] = 1'b0;
  endtask

  task automatic finish_op(input int l, output int lat);
    lat = 0;
    while (!mem_out_valid[l] && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic op(input int l, input bit wr, input bit rd, input logic [31:0] a,
                    input logic [31:0] d, input string name, input int exp_lat);
    int lat;
    start_op(l, wr, rd, a, d);
    finish_op(l, lat);
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int lat, r0, w0, highs, run, max_run;
    for (int l = 0; l < NL; l++) begin
      mem_addr[l] = '0; mem_in[l] = '0; mem_wrreq[l] = 1'b0; mem_rdreq[l] = 1'b0;
    end
    #12;
    check("rst_valid", {31'b0, mem_out_valid[0]}, 32'd1);
    check("rst_mem_out", mem_out[0], 32'h0);
    check("rst_ce_n", {31'b0, sram_ce_n[0]}, 32'd1);
    check("rst_oe_n", {31'b0, sram_oe_n[0]}, 32'd1);
    check("rst_we_n", {31'b0, sram_we_n[0]}, 32'd1);
    check("rst_dq_oe", {31'b0, sram_dq_oe[0]}, 32'd0);
    check("rst_sram_addr", {14'b0, sram_addr[0]}, 32'h0);
    check("rst_dq_out", {16'b0, sram_dq_out[0]}, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Single write: two 3-cycle strobes at halfwords 0 then 1.
    w0 = lane[0].we_cnt;
    op(0, 1, 0, 32'h8000_0000, 32'h0fff_0001, "wr0", 10);
    check("wr0_pulses", lane[0].we_cnt - w0, 32'd2);
    check("wr0_lo_len", lane[0].we_len_log[w0 % 64], 32'd3);
    check("wr0_hi_len", lane[0].we_len_log[(w0 + 1) % 64], 32'd3);
    check("wr0_lo_addr", {14'b0, lane[0].we_addr_log[w0 % 64]}, 32'd0);
    check("wr0_hi_addr", {14'b0, lane[0].we_addr_log[(w0 + 1) % 64]}, 32'd1);
    check("wr0_sram0", {16'b0, lane[0].sram_mem[0]}, 32'h0001);
    check("wr0_sram1", {16'b0, lane[0].sram_mem[1]}, 32'h0fff);

    // Fill and read back the third word.
    for (int i = 1; i < 4; i++)
      op(0, 1, 0, 32'h8000_0000 + 32'(4 * i), 32'h0fff_0001 + 32'(i), "wrfill", 10);
    r0 = lane[0].rd_n;
    op(0, 0, 1, 32'h8000_0008, 32'h0, "rd8", 6);
    check("rd8_data", mem_out[0], 32'h0fff_0003);
    check("rd8_strobes", lane[0].rd_n - r0, 32'd2);
    check("rd8_lo_addr", {14'b0, lane[0].rd_log[r0 % 64]}, 32'd4);
    check("rd8_hi_addr", {14'b0, lane[0].rd_log[(r0 + 1) % 64]}, 32'd5);

    // Simultaneous requests: write wins, read data stays put.
    r0 = lane[0].rd_n;
    op(0, 1, 1, 32'h8000_0004, 32'hdead_beef, "prio", 10);
    check("prio_mem_out", mem_out[0], 32'h0fff_0003);
    check("prio_no_read", lane[0].rd_n - r0, 32'd0);
    op(0, 0, 1, 32'h8000_0004, 32'h0, "prio_rd", 6);
    check("prio_rd_data", mem_out[0], 32'hdead_beef);

    // Read pulse during a busy write is dropped.
    r0 = lane[0].rd_n;
    start_op(0, 1, 0, 32'h8000_0010, 32'h55aa_33cc);
    @(posedge clk); #1;
    mem_rdreq[0] = 1'b1;
    @(posedge clk); #1;
    mem_rdreq[0] = 1'b0;
    finish_op(0, lat);
    check("busy_wr_latency", lat + 2, 32'd10);
    repeat (3) @(posedge clk);
    #1;
    check("busy_no_read", lane[0].rd_n - r0, 32'd0);

    // Aliasing above the SRAM window.
    op(0, 1, 0, 32'h8008_0000, 32'h1234_5678, "alias_wr", 10);
    check("alias_sram0", {16'b0, lane[0].sram_mem[0]}, 32'h5678);
    check("alias_sram1", {16'b0, lane[0].sram_mem[1]}, 32'h1234);
    op(0, 0, 1, 32'h8000_0000, 32'h0, "alias_rd", 6);
    check("alias_rd_data", mem_out[0], 32'h1234_5678);

    // Asynchronous reset in the middle of a write strobe.
    start_op(0, 1, 0, 32'h8000_0100, 32'hcafe_f00d);
    lat = 0;
    while (sram_we_n[0] && lat < 20) begin
      @(negedge clk); lat++;
    end
    check("mid_wr_strobe_seen", {31'b0, sram_we_n[0]}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_we_n", {31'b0, sram_we_n[0]}, 32'd1);
    check("arst_ce_n", {31'b0, sram_ce_n[0]}, 32'd1);
    check("arst_dq_oe", {31'b0, sram_dq_oe[0]}, 32'd0);
    check("arst_valid", {31'b0, mem_out_valid[0]}, 32'd1);
    check("arst_mem_out", mem_out[0], 32'h0);
    check("arst_sram_addr", {14'b0, sram_addr[0]}, 32'h0);
    check("arst_dq_out", {16'b0, sram_dq_out[0]}, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    op(0, 0, 1, 32'h8000_0000, 32'h0, "post_rst_rd", 6);
    check("post_rst_rd_data", mem_out[0], 32'h1234_5678);

    // Zero-wait lane: latencies and back-to-back held reads.
    op(1, 1, 0, 32'h8000_0020, 32'ha5a5_0f0f, "w0_wr", 6);
    op(1, 0, 1, 32'h8000_0020, 32'h0, "w0_rd", 2);
    check("w0_rd_data", mem_out[1], 32'ha5a5_0f0f);
    @(posedge clk); #1;
    wait_idle(1);
    mem_addr[1] = 32'h8000_0020; mem_rdreq[1] = 1'b1;
    highs = 0; run = 0; max_run = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (mem_out_valid[1]) begin
        highs++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    mem_rdreq[1] = 1'b0;
    check("held_rd_valid_highs", highs, 32'd3);
    check("held_rd_valid_run", max_run, 32'd1);
    wait_idle(1);
    check("held_rd_data", mem_out[1], 32'ha5a5_0f0f);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1);
  end

endmodule
